tmp_spi_reader: RTL
===================

Name: tmp_spi_reader

Overview:
- Upstream acquisition stage: polls an external SPI temperature sensor at a fixed rate.
- Sensor type: TMP121-style, 16-bit frame, 13-bit two's-complement value, 0.0625 °C/LSB.
- Converts each reading to an integer °C clamped to 0..99.
- Drives the 8-bit TMP bus consumed by the temperature-classification and BCD stages.

Parameters:
- SCK_HALF, 50: system clocks per SCK half-period (1 MHz SCK at 100 MHz).
- SAMPLE_PERIOD, 10000000: system clocks between transaction starts (10 Hz).
- TMP_MAX, 99: upper clamp for the integer output.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- spi_miso  input  1  sensor serial data
- spi_cs_n  output  1  sensor chip select, active low
- spi_sck  output  1  SPI clock, mode 0, idle low
- tmp  output  8  integer °C, 0..TMP_MAX
- tmp_valid  output  1  one-cycle pulse when tmp updates
- sensor_err  output  1  last frame was invalid (0xFFFF)

Behaviour:
- Reset values: tmp=0, tmp_valid=0, sensor_err=0, spi_cs_n=1, spi_sck=0. Sample timer=0, FSM=IDLE.
- Reset is asynchronous: asserting rst mid-transaction forces spi_cs_n=1 and spi_sck=0 immediately. The partial frame is discarded.
- Sample timer counts 0..SAMPLE_PERIOD-1 and wraps. Wrap produces a start tick; first transaction begins SAMPLE_PERIOD cycles after reset release.
- FSM states:
  - IDLE: spi_cs_n=1, spi_sck=0. Start tick -> CS_SETUP.
  - CS_SETUP: spi_cs_n=0 for SCK_HALF cycles -> SHIFT.
  - SHIFT: 16 SCK periods, MSB first. SCK rises at the end of each low half.
    - miso is sampled into a 16-bit shift register on the clk edge where SCK goes 0->1.
    - After the 16th high half, SCK returns low -> CS_HOLD.
  - CS_HOLD: spi_cs_n=0, spi_sck=0 for SCK_HALF cycles, then spi_cs_n=1 -> CONVERT.
  - CONVERT: one cycle, -> IDLE.
- CS low duration is exactly 34*SCK_HALF cycles (1700 at defaults).
- A start tick arriving while not in IDLE is dropped; no queuing. The timer keeps free-running.
- Conversion: raw = frame[15:3], signed 13 bits. frame[2:0] is ignored.
  - raw[12]=1 (negative) -> 0.
  - Otherwise int = raw[11:4] (floor, 0..255). int>TMP_MAX -> TMP_MAX.
- frame==16'hFFFF: sensor_err<=1, tmp holds, no tmp_valid pulse.
- Any other frame: sensor_err<=0, tmp<=converted value, tmp_valid=1 for exactly one cycle. Both registered at the end of CONVERT, i.e. the same cycle FSM re-enters IDLE.
- tmp_valid pulses even when the value is unchanged.

Optional Feature:
- Macro TMP_AVG4_EN.
- Defined:
  - tmp is the 4-sample moving average of converted values: 10-bit sum >> 2, floor.
  - The first valid sample after reset preloads all four taps.
  - Error frames do not enter the window.
  - Output latency is unchanged.
- Undefined: tmp is the latest converted sample. No averaging registers are synthesised.

Decomposition:
- Package tmp_pkg:
  - FSM state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, CONVERT).
  - Constants FRAME_BITS=16, RAW_BITS=13, FRAC_BITS=4, ERR_FRAME=16'hFFFF.
- Sub-module tmp_raw_to_int: combinational 16-bit frame -> 8-bit clamped integer plus error flag. Reused by the bench model.

Test Plan:
- Sensor model returns 0x1900 -> raw 800 -> tmp=50, one tmp_valid pulse, sensor_err=0. CS low exactly 1700 cycles; 16 SCK rising edges at 1 µs spacing.
- Frame 0x0C88 (25.06 °C) -> tmp=25 (floor).
- Frame 0x3E80 (125 °C) -> tmp=99 (clamp). Frame 0xFB00 (−10 °C) -> tmp=0.
- After tmp=50, frame 0xFFFF -> sensor_err=1, tmp stays 50, no tmp_valid. Next frame 0x0C88 -> sensor_err=0, tmp=25.
- rst asserted during SHIFT bit 8 -> spi_cs_n=1, spi_sck=0, tmp=0 same cycle. No transaction until SAMPLE_PERIOD cycles after release.
- With TMP_AVG4_EN: frames 40, 40, 80, 80 °C -> tmp sequence 40, 40, 50, 60.

Source files
------------

// File: rtl/tmp_pkg.sv
// Shared types and constants for the SPI temperature reader.
package tmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CONVERT
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int RAW_BITS   = 13;
  localparam int FRAC_BITS  = 4;
  localparam logic [FRAME_BITS-1:0] ERR_FRAME = 16'hFFFF;

endpackage

// File: rtl/tmp_raw_to_int.sv
// Frame to clamped integer degrees C, plus invalid-frame flag.
import tmp_pkg::*;

module tmp_raw_to_int #(
  parameter int TMP_MAX = 99
) (
  input  logic [FRAME_BITS-1:0] frame,
  output logic [7:0]            value,
  output logic                  err
);

  // Raw value sits in frame[15:3]; its integer part is frame[14:7].
  localparam int LSB = FRAME_BITS - RAW_BITS + FRAC_BITS;

  logic       neg;
  logic [7:0] whole;

  assign neg   = frame[FRAME_BITS-1];
  assign whole = frame[LSB+7:LSB];
  assign err   = (frame == ERR_FRAME);

  always_comb begin
    value = whole;
    if (neg)
      value = 8'd0;
    else if (whole > 8'(TMP_MAX))
      value = 8'(TMP_MAX);
  end

endmodule

// File: rtl/tmp_spi_reader.sv
// Periodic SPI poll of a TMP121-style sensor, integer degC output.
// Optional 4-sample moving average enabled by TMP_AVG4_EN.
import tmp_pkg::*;

module tmp_spi_reader #(
  parameter int SCK_HALF      = 50,
  parameter int SAMPLE_PERIOD = 10000000,
  parameter int TMP_MAX       = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic [7:0] tmp,
  output logic       tmp_valid,
  output logic       sensor_err
);

  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam int HW = $clog2(SCK_HALF + 1);

  state_t                state, state_n;
  logic [TW-1:0]         timer;
  logic                  tick;
  logic [HW-1:0]         half_cnt;
  logic                  half_end;
  logic                  sck_q;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [7:0]            conv_val;
  logic                  conv_err;
  logic [7:0]            new_tmp;
  logic                  commit;

  assign tick     = (timer == TW'(SAMPLE_PERIOD - 1));
  assign half_end = (half_cnt == HW'(SCK_HALF - 1));
  assign spi_sck  = sck_q;
  assign spi_cs_n = (state == IDLE) || (state == CONVERT);
  assign commit   = (state == CONVERT) && !conv_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer <= '0;
    else
      timer <= tick ? '0 : timer + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (tick) state_n = CS_SETUP;
      CS_SETUP: if (half_end) state_n = SHIFT;
      SHIFT:
        if (half_end && sck_q && bit_cnt == 4'd15)
          state_n = CS_HOLD;
      CS_HOLD:  if (half_end) state_n = CONVERT;
      CONVERT:  state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      sck_q    <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (state == CS_SETUP || state == SHIFT || state == CS_HOLD)
        half_cnt <= half_end ? '0 : half_cnt + HW'(1);
      else
        half_cnt <= '0;
      if (state == SHIFT) begin
        if (half_end) begin
          sck_q <= ~sck_q;
          // Capture on the edge where SCK rises.
          if (!sck_q)
            shreg <= {shreg[FRAME_BITS-2:0], spi_miso};
          else
            bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        sck_q   <= 1'b0;
        bit_cnt <= '0;
      end
    end
  end

  tmp_raw_to_int #(
    .TMP_MAX (TMP_MAX)
  ) u_conv (
    .frame (shreg),
    .value (conv_val),
    .err   (conv_err)
  );

`ifdef TMP_AVG4_EN
  logic [7:0] tap0, tap1, tap2;
  logic       primed;
  logic [9:0] sum;

  assign sum = 10'(conv_val) + 10'(tap0) + 10'(tap1) + 10'(tap2);
  assign new_tmp = primed ? 8'(sum >> 2) : conv_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap0   <= '0;
      tap1   <= '0;
      tap2   <= '0;
      primed <= 1'b0;
    end else if (commit) begin
      // First sample fills the whole window.
      primed <= 1'b1;
      tap0   <= conv_val;
      tap1   <= primed ? tap0 : conv_val;
      tap2   <= primed ? tap1 : conv_val;
    end
  end
`else
  assign new_tmp = conv_val;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmp        <= '0;
      tmp_valid  <= 1'b0;
      sensor_err <= 1'b0;
    end else begin
      tmp_valid <= 1'b0;
      if (state == CONVERT) begin
        sensor_err <= conv_err;
        if (!conv_err) begin
          tmp       <= new_tmp;
          tmp_valid <= 1'b1;
        end
      end
    end
  end

endmodule
